nibble_serial_addsub_16: RTL and testbench

Multi-cycle 16-bit two's-complement adder/subtractor that computes one 4-bit nibble per clock, least significant nibble first, and registers the carry between nibbles. It sits between the decode/operand-fetch stage and writeback for ALU add/sub operations. It is the sequencing stage that feeds a 4-bit ripple slice built from `full_adder_1bit` cells and collects the slice's outputs. It produces a saturating 16-bit result plus Ovfl/Zero/Neg flags under a start/busy/done handshake.

---
 rtl/nibble_serial_addsub_16.sv | 163 ++++++++++++++++
 tb/tb_nibble_serial_addsub_16.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub_16.sv
// Nibble-serial two's-complement adder/subtractor: one 4-bit ripple slice reused
// LSB-first over WIDTH/4 cycles, with optional saturation and Ovfl/Zero/Neg flags.

module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_serial_addsub_16 #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl,
  output logic             Zero,
  output logic             Neg
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovfl_q, ovfl_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Current nibble operands, selected by k
  logic [3:0]       nib_a, nib_b, nib_s;
  logic [4:0]       c;
  logic [WIDTH+3:0] shift_cat;
  logic [WIDTH-1:0] raw_res, sat_val, final_res;
  logic             ovf_raw;

  assign nib_a = opa_q[{k_q, 2'b00} +: 4];
  assign nib_b = opb_q[{k_q, 2'b00} +: 4];
  assign c[0]  = carry_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_slice
    full_adder_1bit u_fa (
      .a    (nib_a[gi]),
      .b    (nib_b[gi]),
      .cin  (c[gi]),
      .s    (nib_s[gi]),
      .cout (c[gi+1])
    );
  end

  // New nibble enters at the top; after N shifts the register holds the full result.
  assign shift_cat = {nib_s, sh_q};
  assign raw_res   = shift_cat[WIDTH+3:4];
  assign ovf_raw   = c[3] ^ c[4];
  assign sat_val   = opa_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign final_res = (ovf_raw && (SATURATE != 0)) ? sat_val : raw_res;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    k_d     = k_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    ovfl_d  = ovfl_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          carry_d = sub;
          k_d     = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        sh_d    = raw_res;
        carry_d = c[4];
        k_d     = k_q + KW'(1);
        if (k_q == KW'(N - 1)) begin
          sum_d   = final_res;
          ovfl_d  = ovf_raw;
          zero_d  = (final_res == '0);
          neg_d   = final_res[WIDTH-1];
          carry_d = 1'b0;
          k_d     = '0;
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      ovfl_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      ovfl_q  <= ovfl_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Ovfl = ovfl_q;
  assign Zero = zero_q;
  assign Neg  = neg_q;
endmodule

// File: tb/tb_nibble_serial_addsub_16.sv
// Directed bench: one saturating and one wrapping instance share stimulus;
// results, flags, latency, handshake and reset behaviour are checked.

module tb_nibble_serial_addsub_16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic        sub_in = 1'b0;

  logic        busy_s, done_s, ovfl_s, zero_s, neg_s;
  logic [15:0] sum_s;
  logic        busy_w, done_w, ovfl_w, zero_w, neg_w;
  logic [15:0] sum_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub_16 #(.WIDTH(16), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in), .sub(sub_in),
    .busy(busy_s), .done(done_s), .Sum(sum_s), .Ovfl(ovfl_s), .Zero(zero_s), .Neg(neg_s)
  );

  nibble_serial_addsub_16 #(.WIDTH(16), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in), .sub(sub_in),
    .busy(busy_w), .done(done_w), .Sum(sum_w), .Ovfl(ovfl_w), .Zero(zero_w), .Neg(neg_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Presents a request over one rising edge; returns #1 after that edge (E0).
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    a_in = a; b_in = b; sub_in = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after E0 until done (bounded); busy_cnt includes the E0 sample.
  task automatic wait_done(input int cyc0, output int cyc, output int busy_cnt);
    cyc = cyc0;
    busy_cnt = busy_s ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 cyc++;
      if (done_s) return;
      if (busy_s) busy_cnt++;
    end
    cyc = 999;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] exp_sat, input logic [15:0] exp_wrap,
                        input logic exp_ovf, input logic exp_zero);
    int cyc, bc;
    issue(a, b, s);
    wait_done(0, cyc, bc);
    $display("op %s: A=%h B=%h sub=%0d -> sat %h wrap %h ovf %0d cycles %0d",
             tag, a, b, s, sum_s, sum_w, ovfl_s, cyc);
    check({tag, "_lat"}, cyc, 4);
    check({tag, "_sum_sat"}, sum_s, exp_sat);
    check({tag, "_sum_wrap"}, sum_w, exp_wrap);
    check({tag, "_ovfl"}, {ovfl_s, ovfl_w}, {exp_ovf, exp_ovf});
    check({tag, "_zero"}, {zero_s, zero_w}, {exp_zero, exp_zero});
    check({tag, "_neg"}, {neg_s, neg_w}, {exp_sat[15], exp_wrap[15]});
  endtask

  initial begin
    int cyc, bc, ndone;
    #1;
    check("rst_outs", {busy_s, done_s, ovfl_s, zero_s, neg_s, sum_s}, '0);
    @(negedge clk) rst = 1'b0;

    // Basic add with latency/busy checks
    issue(16'h1234, 16'h0F0F, 1'b0);
    check("e0_busy", {busy_s, done_s}, 2'b10);
    wait_done(0, cyc, bc);
    $display("op add: sum %h cycles %0d busy %0d", sum_s, cyc, bc);
    check("add_lat", cyc, 4);
    check("add_busy_cycles", bc, 4);
    check("add_sum", sum_s, 16'h2143);
    check("add_flags", {ovfl_s, zero_s, neg_s, busy_s}, 4'b0000);
    @(posedge clk); #1;
    check("done_one_cycle", {done_s, busy_s}, 2'b00);
    check("hold_idle", sum_s, 16'h2143);

    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_zero", 16'h1234, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b0);
    run_op("neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b0);

    // Start during RUN is ignored
    issue(16'h1111, 16'h1111, 1'b0);
    @(posedge clk); #1;
    check("hold_in_run", sum_s, 16'h8000);
    @(negedge clk);
    a_in = 16'h0001; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(2, cyc, bc);
    $display("op ignore_start: sum %h cycles %0d", sum_s, cyc);
    check("ign_lat", cyc, 4);
    check("ign_sum", sum_s, 16'h2222);

    // Back-to-back start in the DONE cycle
    issue(16'h0003, 16'h0004, 1'b0);
    check("b2b_busy", {busy_s, done_s}, 2'b10);
    wait_done(0, cyc, bc);
    $display("op back_to_back: sum %h cycles %0d", sum_s, cyc);
    check("b2b_lat", cyc, 4);
    check("b2b_sum", sum_s, 16'h0007);

    // Reset mid-RUN
    issue(16'h5555, 16'h1111, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    $display("op reset_mid_run: sum %h busy %0d done %0d", sum_s, busy_s, done_s);
    check("midrst_outs", {busy_s, done_s, ovfl_s, zero_s, neg_s, sum_s}, '0);
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done_s || busy_s) ndone++;
    end
    check("midrst_quiet", ndone, 0);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 16'h0002, 1'b0, 1'b0);

    // rst and start together: start is lost
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a_in = 16'h0009; b_in = 16'h0009; sub_in = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done_s || busy_s) ndone++;
    end
    $display("op rst_with_start: sum %h activity %0d", sum_s, ndone);
    check("rst_start_lost", {ndone[7:0], sum_s}, 24'h000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
